// File: rtl/fir_sched_pkg.sv
// Shared defaults and state type for the FIR bank scheduler.
package fir_sched_pkg;

  localparam int DATA_W    = 10;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int DIV_W     = 8;
  localparam int SETTLE    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

endpackage

// File: rtl/fir_sched_ratecnt.sv
// Sample-rate strobe generator plus the settle delay line that marks the
// cycle in which the FIR bank outputs are valid for capture.
module fir_sched_ratecnt #(
  parameter int DIV_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic             run,
  input  logic [DIV_W-1:0] rate_div,
  output logic             filt_en_o,
  output logic             cap_pt_o,
  output logic             inflight_o
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [SETTLE-1:0] sh_q, sh_d;
  logic              strobe;

  always_comb begin
    strobe = run & (cnt_q == '0);
    cnt_d  = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = rate_div;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    // Shift toward the MSB; the cast drops the oldest bit.
    sh_d = SETTLE'({sh_q, strobe});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clk_enable) begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign filt_en_o  = strobe & clk_enable & ~rst;
  assign cap_pt_o   = sh_q[SETTLE-1] & clk_enable;
  assign inflight_o = |sh_q;

endmodule

// File: rtl/fir_bank_scheduler.sv
// Strobes the cascaded FIR bank, captures its lane outputs and serialises them
// onto a valid/ready stream. Define DROP_CNT_EN to add the drop_cnt output.
module fir_bank_scheduler #(
  parameter int DATA_W    = fir_sched_pkg::DATA_W,
  parameter int NUM_LANES = fir_sched_pkg::NUM_LANES,
  parameter int DIV_W     = fir_sched_pkg::DIV_W,
  parameter int SETTLE    = fir_sched_pkg::SETTLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_enable,
  input  logic                          run,
  input  logic [DIV_W-1:0]              rate_div,
  input  logic                          ovr_clr,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_data,
  output logic                          filt_en,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic [$clog2(NUM_LANES)-1:0]  m_lane,
  output logic                          m_last,
  output logic                          overrun,
  output logic                          busy
`ifdef DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  import fir_sched_pkg::*;

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  logic [NUM_LANES-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [LW-1:0]                    lane_q, lane_d;
  sched_state_t                     state_q, state_d;
  logic                             ovr_q, ovr_d;
  logic                             cap_pt, inflight;
  logic                             hs, last_hs, drop;

  fir_sched_ratecnt #(
    .DIV_W (DIV_W),
    .SETTLE(SETTLE)
  ) u_ratecnt (
    .clk       (clk),
    .rst       (reset),
    .clk_enable(clk_enable),
    .run       (run),
    .rate_div  (rate_div),
    .filt_en_o (filt_en),
    .cap_pt_o  (cap_pt),
    .inflight_o(inflight)
  );

  assign hs      = clk_enable & (state_q == DRAIN) & m_ready;
  assign last_hs = hs & (lane_q == LAST_LANE);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_pt) begin
          buf_d   = lane_data;
          lane_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // A frame landing on the final handshake chains straight on.
        if (cap_pt && last_hs) begin
          buf_d  = lane_data;
          lane_d = '0;
        end else begin
          drop = cap_pt;
          if (last_hs) begin
            lane_d  = '0;
            state_d = IDLE;
          end else if (hs) begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovr_d = ovr_q;
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clk_enable && ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      buf_q   <= '0;
      ovr_q   <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign m_valid = (state_q == DRAIN);
  assign m_data  = m_valid ? buf_q[lane_q] : '0;
  assign m_lane  = m_valid ? lane_q : '0;
  assign m_last  = m_valid & (lane_q == LAST_LANE);
  assign overrun = ovr_q;
  assign busy    = ~reset & (run | inflight | (state_q != IDLE));

`ifdef DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (clk_enable && ovr_clr) begin
      dcnt_d = drop ? 16'd1 : '0;
    end else if (drop && (dcnt_q != '1)) begin
      dcnt_d = dcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end

  assign drop_cnt = dcnt_q;
`endif

endmodule

// File: tb/tb_fir_bank_scheduler.sv
// Self-checking bench for fir_bank_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fir_bank_scheduler;

  localparam int DW = 10;
  localparam int NL = 4;
  localparam int DV = 8;
  localparam int ST = 2;
  localparam int LW = $clog2(NL);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_enable = 1'b1;
  logic              run = 1'b0;
  logic [DV-1:0]     rate_div = '0;
  logic              ovr_clr = 1'b0;
  logic [NL*DW-1:0]  lane_data = '0;
  logic              m_ready = 1'b0;
  logic              filt_en, m_valid, m_last, overrun, busy;
  logic [DW-1:0]     m_data;
  logic [LW-1:0]     m_lane;
`ifdef DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_bank_scheduler #(
    .DATA_W   (DW),
    .NUM_LANES(NL),
    .DIV_W    (DV),
    .SETTLE   (ST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .run       (run),
    .rate_div  (rate_div),
    .ovr_clr   (ovr_clr),
    .lane_data (lane_data),
    .filt_en   (filt_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_lane    (m_lane),
    .m_last    (m_last),
    .overrun   (overrun),
    .busy      (busy)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Reference model: cycles until next strobe, ages of strobes in flight,
  // the frame being drained and the sticky overrun flag.
  int unsigned   mwait;
  int            ages[$];
  logic [DW-1:0] mframe[NL];
  int            midx;
  bit            mactive, movr, mcap;
  logic          e_filt, e_valid, e_last, e_busy, e_ovr;
  logic [DW-1:0] e_data;
  logic [LW-1:0] e_lane;

  function automatic void model_reset();
    mwait = 0;
    ages.delete();
    for (int i = 0; i < NL; i++) mframe[i] = '0;
    midx = 0;
    mactive = 0;
    movr = 0;
  endfunction

  function automatic void model_eval();
    mcap = 0;
    foreach (ages[i]) if (ages[i] == ST && clk_enable) mcap = 1;
    e_filt  = !reset && clk_enable && run && (mwait == 0);
    e_valid = !reset && mactive;
    e_data  = mframe[midx];
    e_lane  = LW'(midx);
    e_last  = (midx == NL - 1);
    e_busy  = !reset && (run || ages.size() != 0 || mactive);
    e_ovr   = movr;
  endfunction

  function automatic void model_step();
    bit strobe, hs, lasths, dropped;
    int nages[$];
    if (reset) begin
      model_reset();
      return;
    end
    if (!clk_enable) return;
    model_eval();
    strobe  = run && (mwait == 0);
    hs      = mactive && m_ready;
    lasths  = hs && (midx == NL - 1);
    dropped = mcap && mactive && !lasths;
    if (mcap && !dropped) begin
      for (int i = 0; i < NL; i++) mframe[i] = lane_data[i*DW +: DW];
      midx = 0;
      mactive = 1;
    end else if (lasths) begin
      mactive = 0;
      midx = 0;
    end else if (hs) begin
      midx++;
    end
    if (dropped) movr = 1;
    else if (ovr_clr) movr = 0;
    foreach (ages[i]) if (ages[i] != ST) nages.push_back(ages[i] + 1);
    if (strobe) nages.push_back(1);
    ages = nages;
    if (!run) mwait = 0;
    else if (mwait == 0) mwait = rate_div;
    else mwait = mwait - 1;
  endfunction

  always @(posedge clk) model_step();

  function automatic logic [NL*DW-1:0] rand_frame();
    logic [NL*DW-1:0] f;
    for (int i = 0; i < NL; i++) f[i*DW +: DW] = DW'($urandom);
    return f;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; clk_enable = 1'b1; ovr_clr = 1'b0; m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b1; clk_enable = 1'b1; rate_div = 8'd3; m_ready = 1'b1;
    lane_data = rand_frame();
    model_reset();
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({filt_en, m_valid, m_data, m_lane, m_last, overrun, busy} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs c=%0d got fe=%b v=%b d=%0d l=%0d last=%b ovr=%b busy=%b exp all 0",
                 c, filt_en, m_valid, m_data, m_lane, m_last, overrun, busy);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (filt_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_first_strobe got %b exp 1", filt_en);
    end
  endtask

  task automatic test_basic();
    int ph, ln;
    logic ev;
    apply_reset();
    lane_data = {10'd40, 10'd30, 10'd20, 10'd10};
    rate_div = 8'd7; m_ready = 1'b1; run = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      ph = (c >= 3) ? (c - 3) % 8 : 8;
      ev = (ph < 4);
      ln = ph;
      vectors++;
      if (filt_en !== (c % 8 == 0)) begin
        miscompares++;
        $display("FAIL basic_filt_en c=%0d got %b exp %b", c, filt_en, (c % 8 == 0));
      end
      vectors++;
      if (m_valid !== ev) begin
        miscompares++;
        $display("FAIL basic_valid c=%0d got %b exp %b", c, m_valid, ev);
      end
      if (ev) begin
        vectors++;
        if ({m_data, m_lane, m_last} !== {DW'(10 * (ln + 1)), LW'(ln), (ln == 3)}) begin
          miscompares++;
          $display("FAIL basic_lane c=%0d got d=%0d l=%0d last=%b exp d=%0d l=%0d last=%b",
                   c, m_data, m_lane, m_last, 10 * (ln + 1), ln, (ln == 3));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [NL*DW-1:0] fr;
    logic eo;
    apply_reset();
    fr = rand_frame();
    lane_data = fr; rate_div = 8'd7; m_ready = 1'b0; run = 1'b1;
    for (int c = 0; c < 28; c++) begin
      ovr_clr = (c == 21);
      #1;
      vectors++;
      if (m_valid !== (c >= 3)) begin
        miscompares++;
        $display("FAIL bp_valid c=%0d got %b exp %b", c, m_valid, (c >= 3));
      end
      if (c >= 3) begin
        vectors++;
        if ({m_data, m_lane} !== {fr[DW-1:0], LW'(0)}) begin
          miscompares++;
          $display("FAIL bp_hold c=%0d got d=%0d l=%0d exp d=%0d l=0", c, m_data, m_lane, fr[DW-1:0]);
        end
      end
      if (c != 10) begin
        eo = (c >= 11 && c <= 21) || (c >= 27);
        vectors++;
        if (overrun !== eo) begin
          miscompares++;
          $display("FAIL bp_overrun c=%0d got %b exp %b", c, overrun, eo);
        end
      end
`ifdef DROP_CNT_EN
      if (c == 11 || c == 19 || c == 22) begin
        vectors++;
        if (drop_cnt !== ((c == 11) ? 16'd1 : (c == 19) ? 16'd2 : 16'd0)) begin
          miscompares++;
          $display("FAIL bp_drop_cnt c=%0d got %0d", c, drop_cnt);
        end
      end
`endif
      @(negedge clk);
    end
    ovr_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NL*DW-1:0] fr[8];
    logic [NL*DW-1:0] cur;
    int f, ln;
    apply_reset();
    foreach (fr[i]) fr[i] = rand_frame();
    rate_div = 8'd3; m_ready = 1'b1; run = 1'b1;
    for (int c = 0; c < 24; c++) begin
      lane_data = fr[(c < 2) ? 0 : (c - 2) / 4];
      #1;
      vectors++;
      if ({m_valid, overrun} !== {(c >= 3), 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_valid_ovr c=%0d got v=%b o=%b exp v=%b o=0", c, m_valid, overrun, (c >= 3));
      end
      if (c >= 3) begin
        f = (c - 3) / 4;
        ln = (c - 3) % 4;
        cur = fr[f];
        vectors++;
        if ({m_data, m_lane, m_last} !== {cur[ln*DW +: DW], LW'(ln), (ln == 3)}) begin
          miscompares++;
          $display("FAIL b2b_lane c=%0d got d=%0d l=%0d last=%b exp d=%0d l=%0d last=%b",
                   c, m_data, m_lane, m_last, cur[ln*DW +: DW], ln, (ln == 3));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clk_enable();
    int exp_lane[13] = '{-1, -1, -1, 0, 1, 1, 1, 1, 2, 3, -1, -1, -1};
    logic [NL*DW-1:0] fr;
    apply_reset();
    fr = rand_frame();
    lane_data = fr; rate_div = 8'd7; m_ready = 1'b1; run = 1'b1;
    for (int c = 0; c < 13; c++) begin
      clk_enable = !(c >= 4 && c <= 6);
      #1;
      vectors++;
      if (filt_en !== (c == 0 || c == 11)) begin
        miscompares++;
        $display("FAIL ce_filt_en c=%0d got %b exp %b", c, filt_en, (c == 0 || c == 11));
      end
      vectors++;
      if (m_valid !== (exp_lane[c] >= 0)) begin
        miscompares++;
        $display("FAIL ce_valid c=%0d got %b exp %b", c, m_valid, (exp_lane[c] >= 0));
      end
      if (exp_lane[c] >= 0) begin
        vectors++;
        if ({m_lane, m_data} !== {LW'(exp_lane[c]), fr[exp_lane[c]*DW +: DW]}) begin
          miscompares++;
          $display("FAIL ce_lane c=%0d got l=%0d d=%0d exp l=%0d d=%0d",
                   c, m_lane, m_data, exp_lane[c], fr[exp_lane[c]*DW +: DW]);
        end
      end
      @(negedge clk);
    end
    clk_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    lane_data = {10'd40, 10'd30, 10'd20, 10'd10};
    rate_div = 8'd7; m_ready = 1'b0; run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c >= 3) begin
        vectors++;
        if (m_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL rmid_pre_valid c=%0d got %b exp 1", c, m_valid);
        end
      end
      @(negedge clk);
    end
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({m_valid, m_data, busy} !== '0) begin
      miscompares++;
      $display("FAIL rmid_reset got v=%b d=%0d busy=%b exp 0 0 0", m_valid, m_data, busy);
    end
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if ({m_valid, filt_en} !== 2'b00) begin
        miscompares++;
        $display("FAIL rmid_after c=%0d got v=%b fe=%b exp 0 0", c, m_valid, filt_en);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      clk_enable = ($urandom_range(0, 9) != 0);
      run        = ($urandom_range(0, 15) != 0);
      rate_div   = DV'($urandom_range(0, 9));
      m_ready    = ($urandom_range(0, 2) != 0);
      ovr_clr    = ($urandom_range(0, 19) == 0);
      lane_data  = rand_frame();
      reset      = ($urandom_range(0, 199) == 0);
      if (reset) model_reset();
      #1;
      model_eval();
      vectors++;
      if ({filt_en, m_valid, overrun, busy} !== {e_filt, e_valid, e_ovr, e_busy}) begin
        miscompares++;
        $display("FAIL rand_ctrl c=%0d got fe=%b v=%b o=%b b=%b exp fe=%b v=%b o=%b b=%b",
                 c, filt_en, m_valid, overrun, busy, e_filt, e_valid, e_ovr, e_busy);
      end
      if (e_valid) begin
        vectors++;
        if ({m_data, m_lane, m_last} !== {e_data, e_lane, e_last}) begin
          miscompares++;
          $display("FAIL rand_data c=%0d got d=%0d l=%0d last=%b exp d=%0d l=%0d last=%b",
                   c, m_data, m_lane, m_last, e_data, e_lane, e_last);
        end
      end
      @(negedge clk);
    end
    reset = 1'b0; ovr_clr = 1'b0; clk_enable = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_clk_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
